// File: rtl/ps2_ascii_source.sv
// PS/2 keyboard receiver with a scan-code-set-2 to ASCII decoder.
// Turns PS/2 frames into one-cycle ASCII strobes for a character display.
//
// Ports:
//   clk_25M   - system clock, the only clock domain
//   rst       - synchronous, active-high reset
//   ps2_clk   - asynchronous PS/2 clock line from the keyboard
//   ps2_data  - asynchronous PS/2 data line from the keyboard
//   ascii     - decoded character; holds its last value between strobes
//   ascii_val - one-cycle strobe qualifying ascii (no backpressure)
//   frame_err - one-cycle pulse on start, parity, stop or timeout error
module ps2_ascii_source #(
    parameter int unsigned p_timeout_cycles = 25000
) (
    input  logic       clk_25M,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       ascii_val,
    output logic       frame_err
);

    localparam int unsigned TMO_W = $clog2(p_timeout_cycles + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(p_timeout_cycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e           state_q;
    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_prev_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [TMO_W-1:0] tmo_q;
    logic             break_pend_q;
    logic             ext_pend_q;
    logic             shift_l_q;
    logic             shift_r_q;
    logic [7:0]       ascii_q;
    logic             ascii_val_q;
    logic             frame_err_q;

    logic       fall_c;
    logic       bit_c;
    logic       parity_ok_c;
    logic [7:0] map_char_c;
    logic       map_hit_c;
    logic       map_letter_c;
    logic [7:0] out_char_c;

    // Falling edge of the synchronized PS/2 clock; data is sampled only here.
    assign fall_c      = clk_prev_q & ~clk_sync_q[1];
    assign bit_c       = data_sync_q[1];
    assign parity_ok_c = ^{shift_q, parity_q};

    // Make-code lookup for scan code set 2; 8'h00 means unmapped.
    always_comb begin
        map_char_c = 8'h00;
        case (shift_q)
            8'h1C: map_char_c = 8'h61;  // a
            8'h32: map_char_c = 8'h62;  // b
            8'h21: map_char_c = 8'h63;  // c
            8'h23: map_char_c = 8'h64;  // d
            8'h24: map_char_c = 8'h65;  // e
            8'h2B: map_char_c = 8'h66;  // f
            8'h34: map_char_c = 8'h67;  // g
            8'h33: map_char_c = 8'h68;  // h
            8'h43: map_char_c = 8'h69;  // i
            8'h3B: map_char_c = 8'h6A;  // j
            8'h42: map_char_c = 8'h6B;  // k
            8'h4B: map_char_c = 8'h6C;  // l
            8'h3A: map_char_c = 8'h6D;  // m
            8'h31: map_char_c = 8'h6E;  // n
            8'h44: map_char_c = 8'h6F;  // o
            8'h4D: map_char_c = 8'h70;  // p
            8'h15: map_char_c = 8'h71;  // q
            8'h2D: map_char_c = 8'h72;  // r
            8'h1B: map_char_c = 8'h73;  // s
            8'h2C: map_char_c = 8'h74;  // t
            8'h3C: map_char_c = 8'h75;  // u
            8'h2A: map_char_c = 8'h76;  // v
            8'h1D: map_char_c = 8'h77;  // w
            8'h22: map_char_c = 8'h78;  // x
            8'h35: map_char_c = 8'h79;  // y
            8'h1A: map_char_c = 8'h7A;  // z
            8'h45: map_char_c = 8'h30;  // 0
            8'h16: map_char_c = 8'h31;  // 1
            8'h1E: map_char_c = 8'h32;  // 2
            8'h26: map_char_c = 8'h33;  // 3
            8'h25: map_char_c = 8'h34;  // 4
            8'h2E: map_char_c = 8'h35;  // 5
            8'h36: map_char_c = 8'h36;  // 6
            8'h3D: map_char_c = 8'h37;  // 7
            8'h3E: map_char_c = 8'h38;  // 8
            8'h46: map_char_c = 8'h39;  // 9
            8'h29: map_char_c = 8'h20;  // space
            8'h5A: map_char_c = 8'h0A;  // enter
            8'h66: map_char_c = 8'h08;  // backspace
            default: map_char_c = 8'h00;
        endcase
    end

    assign map_hit_c    = (map_char_c != 8'h00);
    assign map_letter_c = (map_char_c >= 8'h61) && (map_char_c <= 8'h7A);
    // Only letters respond to shift.
    assign out_char_c   = (map_letter_c && (shift_l_q || shift_r_q)) ?
                          (map_char_c - 8'h20) : map_char_c;

    // Synchronizers, frame FSM, timeout and decoder flags.
    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            clk_prev_q   <= 1'b1;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            shift_l_q    <= 1'b0;
            shift_r_q    <= 1'b0;
            ascii_q      <= 8'h00;
            ascii_val_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            ascii_val_q <= 1'b0;
            frame_err_q <= 1'b0;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];

            // Inter-edge timeout: abandon a stalled frame.
            if (fall_c) begin
                tmo_q <= '0;
            end else if (state_q != ST_IDLE) begin
                if (tmo_q == TMO_LAST) begin
                    state_q     <= ST_IDLE;
                    tmo_q       <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end

            if (fall_c) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!bit_c) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {bit_c, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= bit_c;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (bit_c && parity_ok_c) begin
                            if (shift_q == 8'hF0) begin
                                break_pend_q <= 1'b1;
                            end else if (shift_q == 8'hE0) begin
                                ext_pend_q <= 1'b1;
                            end else begin
                                break_pend_q <= 1'b0;
                                ext_pend_q   <= 1'b0;
                                if (shift_q == 8'h12) begin
                                    shift_l_q <= ~break_pend_q;
                                end else if (shift_q == 8'h59) begin
                                    shift_r_q <= ~break_pend_q;
                                end else if (!break_pend_q && !ext_pend_q && map_hit_c) begin
                                    ascii_q     <= out_char_c;
                                    ascii_val_q <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ascii     = ascii_q;
    assign ascii_val = ascii_val_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_ascii_source.md
PS2_ASCII_SOURCE -- requirements
Module: ps2_ascii_source

Interface
REQ-001 SHALL have parameter p_timeout_cycles, default 25000, meaning max clk_25M cycles between PS/2 falling edges inside one frame (1 ms at 25 MHz).
REQ-002 SHALL have port clk_25M  input  1  system clock; sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ps2_clk  input  1  asynchronous PS/2 keyboard clock line.
REQ-005 SHALL have port ps2_data  input  1  asynchronous PS/2 keyboard data line.
REQ-006 SHALL have port ascii  output  8  decoded ASCII character, the producer side of the character-display ASCII interface.
REQ-007 SHALL have port ascii_val  output  1  one-cycle strobe qualifying ascii; no backpressure exists.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-009 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer, then detect a falling edge of the synchronized ps2_clk (prev 1, now 0).
REQ-010 SHALL sample synchronized ps2_data only in cycles with a detected falling edge.
REQ-011 SHALL run a frame FSM with states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: on edge with data=0 -> DATA, bit count 0; on edge with data=1 -> stay IDLE, pulse frame_err.
REQ-013 DATA: shift in 8 bits LSB first; after the 8th edge -> PARITY.
REQ-014 PARITY: capture parity bit; odd parity over 8 data bits plus parity bit required; -> STOP.
REQ-015 STOP: on edge, if data=1 and parity good, deliver byte to the decoder; otherwise pulse frame_err and discard; -> IDLE in both cases.
REQ-016 SHALL count cycles since the last falling edge while not IDLE; on reaching p_timeout_cycles -> IDLE, discard partial byte, pulse frame_err.
REQ-017 Decoder SHALL hold flags break_pend, ext_pend, shift_l, shift_r.
REQ-018 Byte 0xF0 SHALL set break_pend; byte 0xE0 SHALL set ext_pend; neither produces output.
REQ-019 Any other byte SHALL clear break_pend and ext_pend after being processed.
REQ-020 Byte 0x12 sets shift_l (cleared if break_pend); 0x59 likewise for shift_r; no output.
REQ-021 Any byte with break_pend set SHALL produce no output.
REQ-022 Any byte with ext_pend set (other than 0xF0) SHALL produce no output.
REQ-023 Make codes SHALL map per scan-code set 2: letters a-z (e.g. 0x1C->'a', 0x32->'b', 0x1A->'z'); digits (0x45->'0', 0x16->'1' ... 0x46->'9'); 0x29->0x20; 0x5A->0x0A; 0x66->0x08.
REQ-024 When shift_l or shift_r is set, letters SHALL map to uppercase (0x20 subtracted); digits, space, enter and backspace are unaffected.
REQ-025 Unmapped make codes SHALL produce no output.
REQ-026 ascii_val SHALL assert exactly one cycle, the cycle after the STOP-bit edge cycle, with ascii valid that cycle.
REQ-027 ascii SHALL hold its last value when ascii_val is low.
REQ-028 A frame error SHALL NOT alter decoder flags.

Reset
REQ-029 On rst: FSM -> IDLE; bit count, timeout counter and all decoder flags -> 0; ascii=8'h00, ascii_val=0, frame_err=0; synchronizers -> 1.
REQ-030 rst mid-frame SHALL discard the partial frame with no ascii_val and no frame_err.

Verification
REQ-031 Frame 0x1C, odd parity -> single ascii_val pulse, ascii=8'h61, one cycle after the stop edge.
REQ-032 Frames 0x12, 0x1C, 0xF0, 0x12, 0x1C -> ascii 8'h41 then 8'h61; no output for 0x12 or the F0 pair.
REQ-033 Frames 0x1C, 0xF0, 0x1C -> exactly one pulse (8'h61); E0 0x75 -> no pulse.
REQ-034 Frame 0x1C with wrong parity -> frame_err one cycle, no ascii_val; next good 0x16 -> 8'h31.
REQ-035 Stop after 4 data bits for p_timeout_cycles -> frame_err pulse, FSM IDLE; next good 0x29 -> 8'h20.
REQ-036 rst asserted after 5 data bits -> no outputs; next good 0x5A -> 8'h0A.
